// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, reset PC, NOP encoding and fetch buffer entry
//               type for the RV32 instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN_DEF-1:0] NOP_INSTR    = 32'h0000_0013;

    // One fetched instruction as held in the fetch buffer.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
        logic                misalign;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
// ============================================================================
// Module      : fetch_buf
// Description : Two-entry fetch FIFO with push/pop/flush and a registered
//               head. When empty, an incoming push is forwarded straight to
//               the head so a response can be consumed in its arrival cycle.
//               The head keeps its last value once the FIFO drains.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_wdata,
    output logic         o_valid,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [2];
    fetch_entry_t r_head;
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_store;
    logic w_deq;

    assign w_empty  = (r_count == 2'd0);
    assign w_full   = (r_count == 2'd2);
    // Empty FIFO, push and pop together: the entry passes through unstored.
    assign w_bypass = w_empty && i_push && i_pop;
    assign w_store  = i_push && !w_bypass;
    assign w_deq    = i_pop && !w_empty;

    assign o_valid  = !w_empty || i_push;
    assign o_count  = r_count;
    assign o_head   = (w_empty && i_push) ? i_wdata : r_head;

    // Pointers, occupancy and the registered head (mirrors mem[rptr] when non-empty).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_head  <= '0;
        end else if (i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_wptr  <= r_wptr ^ w_store;
            r_rptr  <= r_rptr ^ w_deq;
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_deq};
            if (w_empty && i_push) begin
                r_head <= i_wdata;
            end else if (w_deq && w_full) begin
                r_head <= r_mem[~r_rptr];
            end else if (w_deq && w_store) begin
                r_head <= i_wdata;
            end
        end
    end

    // Entry storage; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_store) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // The upstream credit scheme must never push into a full buffer.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            assert (!(i_push && w_full))
                else $error("fetch_buf: push into full buffer");
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : RV32 instruction-fetch stage. Owns the PC, issues requests to
//               a 1-cycle-latency instruction memory under a buffer credit
//               rule, buffers up to two responses and hands them to decode
//               over valid/ready. Redirects flush the buffer and squash the
//               in-flight response.
//               Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned
//               redirect produces a flagged NOP entry and halts fetch).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            id_misalign_o,
`endif
    output logic [XLEN-1:0] id_instr_o
);

    generate
        if (BUF_DEPTH != 2) begin : g_bad_depth
            $error("fetch_stage: BUF_DEPTH must be 2");
        end
        if (XLEN != XLEN_DEF) begin : g_bad_xlen
            $error("fetch_stage: XLEN must match XLEN_DEF");
        end
    endgenerate

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;
    logic            r_drop;

    logic            w_req;
    logic            w_pop;
    logic            w_push;
    logic            w_credit;
    logic            w_halt;
    logic            w_buf_valid;
    logic [1:0]      w_count;
    logic [XLEN-1:0] w_redirect_target;
    fetch_entry_t    w_wdata;
    fetch_entry_t    w_head;

    assign w_pop = id_valid_o && id_ready_i;
    // Occupancy plus outstanding response, less this cycle's pop, must leave room.
    assign w_credit = ({1'b0, w_count} + {2'b00, r_inflight})
                      < (3'(BUF_DEPTH) + {2'b00, w_pop});
    assign w_req    = !rst && !redirect_i && !w_halt && w_credit;

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_halt;
    logic r_mis_pending;
    logic w_mis_redirect;

    assign w_mis_redirect    = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign w_redirect_target = redirect_pc_i;
    assign w_halt            = r_halt;
    assign w_push            = !rst && !redirect_i
                               && ((r_inflight && !r_drop) || r_mis_pending);
    assign id_misalign_o     = !rst && w_head.misalign;

    // Entry source: memory response, or the synthetic NOP for a misaligned target.
    always_comb begin
        w_wdata = '{pc: r_req_pc, instr: imem_rdata_i, misalign: 1'b0};
        if (r_mis_pending) begin
            w_wdata = '{pc: r_pc, instr: NOP_INSTR, misalign: 1'b1};
        end
    end

    // A misaligned redirect queues one flagged entry and stops fetch until the next redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt        <= 1'b0;
            r_mis_pending <= 1'b0;
        end else if (redirect_i) begin
            r_halt        <= w_mis_redirect;
            r_mis_pending <= w_mis_redirect;
        end else begin
            r_mis_pending <= 1'b0;
        end
    end
`else
    logic w_unused_bits;

    assign w_redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign w_halt            = 1'b0;
    assign w_push            = !rst && !redirect_i && r_inflight && !r_drop;
    assign w_unused_bits     = ^{w_head.misalign, redirect_pc_i[1:0]};

    // Every entry comes from the memory response.
    always_comb begin
        w_wdata = '{pc: r_req_pc, instr: imem_rdata_i, misalign: 1'b0};
    end
`endif

    // PC, request tracking and post-redirect response squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
        end else if (redirect_i) begin
            r_pc       <= w_redirect_target;
            r_inflight <= 1'b0;
            r_drop     <= r_inflight;
        end else begin
            r_drop     <= 1'b0;
            r_inflight <= w_req;
            if (w_req) begin
                r_pc     <= r_pc + XLEN'(4);
                r_req_pc <= r_pc;
            end
        end
    end

    fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .i_wdata (w_wdata),
        .o_valid (w_buf_valid),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign id_valid_o = !rst && w_buf_valid;
    assign id_pc_o    = rst ? '0 : w_head.pc;
    assign id_instr_o = rst ? '0 : w_head.instr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a 1-cycle memory
//               model and a queue of expected {pc, instr} pops.
//               Honours FETCH_MISALIGN_CHK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [31:0] R2_PC = 32'h0000_0200;
`else
    localparam logic [31:0] R2_PC = 32'h0000_0203;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        id_misalign_o;
`endif

    int   errs = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t e;

    logic        mem_req_q = 1'b0;
    logic [31:0] mem_addr_q = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory: responds one cycle after each request.
    always @(posedge clk) begin
        mem_req_q  <= imem_req_o;
        mem_addr_q <= imem_addr_o;
    end
    assign imem_rdata_i = mem_req_q ? memf(mem_addr_q) : 32'hBAD0_BAD0;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_pc_o       (id_pc_o),
`ifdef FETCH_MISALIGN_CHK_EN
        .id_misalign_o (id_misalign_o),
`endif
        .id_instr_o    (id_instr_o)
    );

    // Apply inputs mid-cycle, then settle so combinational outputs can be sampled.
    task automatic cyc(input logic r, input logic rdy, input logic red, input logic [31:0] rpc);
        @(negedge clk);
        rst           = r;
        id_ready_i    = rdy;
        redirect_i    = red;
        redirect_pc_i = rpc;
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] pc);
        return '{pc: pc, instr: memf(pc)};
    endfunction

    task automatic test_reset();
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (id_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctl: valid=%b req=%b, required 0 0", id_valid_o, imem_req_o);
        end
        checks++;
        if (id_pc_o !== 32'h0 || id_instr_o !== 32'h0) begin
            errs++;
            $display("FAIL reset_data: pc=%h instr=%h, required 0 0", id_pc_o, id_instr_o);
        end
    endtask

    task automatic test_stream();
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(32'(4 * i)));
        for (int k = 0; k <= 5; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * k)) begin
                errs++;
                $display("FAIL stream_req k=%0d: req=%b addr=%h, required 1 %h", k, imem_req_o, imem_addr_o, 32'(4 * k));
            end
            if (k == 0) begin
                checks++;
                if (id_valid_o !== 1'b0) begin
                    errs++;
                    $display("FAIL stream_first_valid: valid=%b, required 0", id_valid_o);
                end
            end
            if (id_valid_o && id_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL stream_pop: unexpected pc=%h", id_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                        errs++;
                        $display("FAIL stream_pop: pc=%h instr=%h, required %h %h", id_pc_o, id_instr_o, e.pc, e.instr);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL stream_left: %0d pops missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        int nreq;
        nreq = 0;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (imem_req_o) begin
                checks++;
                if (imem_addr_o !== 32'(4 * nreq)) begin
                    errs++;
                    $display("FAIL bp_addr: addr=%h, required %h", imem_addr_o, 32'(4 * nreq));
                end
                nreq++;
            end
        end
        checks++;
        if (nreq != 2) begin
            errs++;
            $display("FAIL bp_nreq: requests=%0d, required 2", nreq);
        end
        checks++;
        if (imem_req_o !== 1'b0 || id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin
            errs++;
            $display("FAIL bp_stall: req=%b valid=%b pc=%h, required 0 1 0", imem_req_o, id_valid_o, id_pc_o);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'(4 * i)));
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            if (k == 0) begin
                checks++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
                    errs++;
                    $display("FAIL bp_refill: req=%b addr=%h, required 1 00000008", imem_req_o, imem_addr_o);
                end
            end
            if (id_valid_o && id_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL bp_pop: unexpected pc=%h", id_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                        errs++;
                        $display("FAIL bp_pop: pc=%h instr=%h, required %h %h", id_pc_o, id_instr_o, e.pc, e.instr);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL bp_left: %0d pops missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_redirect();
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h4));
        exp_q.push_back(mk(32'h100));
        exp_q.push_back(mk(32'h104));
        for (int k = 0; k <= 6; k++) begin
            cyc(1'b0, 1'b1, (k == 3), 32'h100);
            if (k == 3) begin
                checks++;
                if (imem_req_o !== 1'b0 || id_valid_o !== 1'b0) begin
                    errs++;
                    $display("FAIL redir_cycle: req=%b valid=%b, required 0 0", imem_req_o, id_valid_o);
                end
            end
            if (k == 4) begin
                checks++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || id_valid_o !== 1'b0) begin
                    errs++;
                    $display("FAIL redir_next: req=%b addr=%h valid=%b, required 1 00000100 0", imem_req_o, imem_addr_o, id_valid_o);
                end
            end
            if (id_valid_o && id_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL redir_pop: unexpected pc=%h", id_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                        errs++;
                        $display("FAIL redir_pop: pc=%h instr=%h, required %h %h", id_pc_o, id_instr_o, e.pc, e.instr);
                    end
                end
            end
        end
        // Flush of a full buffer; default build also masks the low target bits.
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, R2_PC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (id_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            errs++;
            $display("FAIL redir_flush: valid=%b req=%b addr=%h, required 0 1 00000200", id_valid_o, imem_req_o, imem_addr_o);
        end
        exp_q.push_back(mk(32'h200));
        exp_q.push_back(mk(32'h204));
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            if (id_valid_o && id_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL redir2_pop: unexpected pc=%h", id_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                        errs++;
                        $display("FAIL redir2_pop: pc=%h instr=%h, required %h %h", id_pc_o, id_instr_o, e.pc, e.instr);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL redir_left: %0d pops missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (id_valid_o !== 1'b0 || imem_req_o !== 1'b0 || id_pc_o !== 32'h0) begin
            errs++;
            $display("FAIL rstmid_during: valid=%b req=%b pc=%h, required 0 0 0", id_valid_o, imem_req_o, id_pc_o);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (id_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            errs++;
            $display("FAIL rstmid_release: valid=%b req=%b addr=%h, required 0 1 0", id_valid_o, imem_req_o, imem_addr_o);
        end
        exp_q.push_back(mk(32'h0));
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        e = exp_q.pop_front();
        if (id_valid_o !== 1'b1 || id_pc_o !== e.pc || id_instr_o !== e.instr) begin
            errs++;
            $display("FAIL rstmid_first: valid=%b pc=%h instr=%h, required 1 %h %h", id_valid_o, id_pc_o, id_instr_o, e.pc, e.instr);
        end
    endtask

    task automatic test_wrap();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        exp_q.push_back(mk(32'hFFFF_FFFC));
        exp_q.push_back(mk(32'h0000_0000));
        exp_q.push_back(mk(32'h0000_0004));
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            if (id_valid_o && id_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL wrap_pop: unexpected pc=%h", id_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    if (id_pc_o !== e.pc || id_instr_o !== e.instr) begin
                        errs++;
                        $display("FAIL wrap_pop: pc=%h instr=%h, required %h %h", id_pc_o, id_instr_o, e.pc, e.instr);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL wrap_left: %0d pops missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h102);
        checks++;
        if (imem_req_o !== 1'b0) begin
            errs++;
            $display("FAIL mis_redir_req: req=%b, required 0", imem_req_o);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h102 || id_instr_o !== 32'h13
            || id_misalign_o !== 1'b1 || imem_req_o !== 1'b0) begin
            errs++;
            $display("FAIL mis_entry: valid=%b pc=%h instr=%h mis=%b req=%b, required 1 00000102 00000013 1 0",
                     id_valid_o, id_pc_o, id_instr_o, id_misalign_o, imem_req_o);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (imem_req_o !== 1'b0 || id_valid_o !== 1'b0) begin
                errs++;
                $display("FAIL mis_halt k=%0d: req=%b valid=%b, required 0 0", k, imem_req_o, id_valid_o);
            end
        end
        cyc(1'b0, 1'b1, 1'b1, 32'h200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            errs++;
            $display("FAIL mis_resume: req=%b addr=%h, required 1 00000200", imem_req_o, imem_addr_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_reset_mid();
        test_wrap();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
